// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver: deframes 11-bit frames and keeps the last two valid
// bytes as uppercase ASCII hex in keyCode ({previous, latest}).
module ps2_keycode #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keyCode,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_q, fall_d;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]   key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          timeout_hit;
  logic          frame_ok;

  // A timeout only counts when no falling edge arrives in the same cycle.
  assign timeout_hit = (state_q != ST_IDLE) && !fall_q
                       && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok    = (^shift_q ^ par_q) & data_sync_q;

  // Glitch filter: level flips after FILTER_LEN consecutive differing samples.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
      else                                   filt_cnt_d = filt_cnt_q + FW'(1);
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees
    // pre-edge values regardless of statement order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall_q && !data_sync_q)         state_d = ST_DATA;
      ST_DATA:   if (fall_q && bit_cnt_q == 3'd7)    state_d = ST_PARITY;
      ST_PARITY: if (fall_q)                         state_d = ST_STOP;
      ST_STOP:   if (fall_q)                         state_d = ST_IDLE;
      default:                                       state_d = ST_IDLE;
    endcase
    if (timeout_hit) state_d = ST_IDLE;
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    to_cnt_d    = '0;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (state_q != ST_IDLE && !fall_q) to_cnt_d = to_cnt_q + TW'(1);
    case (state_q)
      ST_IDLE: if (fall_q && !data_sync_q) begin
        bit_cnt_d = '0;
        shift_d   = '0;
      end
      ST_DATA: if (fall_q) begin
        shift_d   = {data_sync_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      ST_PARITY: if (fall_q) par_d = data_sync_q;
      ST_STOP: if (fall_q) begin
        if (frame_ok) begin
          key_code_d  = {key_code_q[15:0], to_hex(shift_q[7:4]), to_hex(shift_q[3:0])};
          key_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (timeout_hit) begin
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
      bit_cnt_d   = '0;
      shift_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      fall_q      <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      fall_q      <= fall_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign keyCode   = key_code_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Directed plus randomized bench for ps2_keycode; expected keyCode comes from a
// history queue of accepted bytes rendered as ASCII hex.
module tb_ps2_keycode;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF           = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keyCode;
  logic        key_valid;
  logic        frame_err;

  ps2_keycode #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keyCode   (keyCode),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int kv_cnt = 0, err_cnt = 0, err_cyc = 0;
  int both_viol = 0, width_viol = 0;
  logic kv_prev = 1'b0, err_prev = 1'b0;
  logic [7:0] hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (frame_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (key_valid === 1'b1 && frame_err === 1'b1) both_viol++;
    if ((key_valid === 1'b1 && kv_prev === 1'b1) || (frame_err === 1'b1 && err_prev === 1'b1))
      width_viol++;
    kv_prev  = key_valid;
    err_prev = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic [7:0] ascii_nibble(input int n);
    return 8'((n < 10) ? 48 + n : 65 + (n - 10));
  endfunction

  function automatic logic [15:0] hex2(input logic [7:0] b);
    return {ascii_nibble(int'(b) / 16), ascii_nibble(int'(b) % 16)};
  endfunction

  function automatic logic [31:0] model_key();
    logic [31:0] e = '0;
    int n = hist.size();
    if (n > 0) e[15:0]  = hex2(hist[n-1]);
    if (n > 1) e[31:16] = hex2(hist[n-2]);
    return e;
  endfunction

  // Frame bits in wire order: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip_par,
                                             input bit bad_stop);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = ~(^b) ^ flip_par;
    f[10]   = ~bad_stop;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int first, input int last,
                           input bit glitch);
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      if (glitch) begin
        repeat (HALF / 2) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - HALF / 2 - 3) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] b, input bit flip_par,
                                input bit bad_stop, input bit glitch);
    int kv0 = kv_cnt;
    int e0  = err_cnt;
    bit ok  = !flip_par && !bad_stop;
    send_bits(make_frame(b, flip_par, bad_stop), 0, 10, glitch);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    if (ok) hist.push_back(b);
    check($sformatf("%s_key", tag), keyCode, model_key());
    check($sformatf("%s_valid_pulses", tag), 32'(kv_cnt - kv0), ok ? 32'd1 : 32'd0);
    check($sformatf("%s_err_pulses", tag), 32'(err_cnt - e0), ok ? 32'd0 : 32'd1);
  endtask

  initial begin
    int kv0, e0;
    logic [7:0] b;
    bit fp, bs;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_key", keyCode, 32'h0);
    check("reset_valid", 32'(key_valid), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);

    send_and_check("f1c", 8'h1C, 1'b0, 1'b0, 1'b0);
    check("f1c_const", keyCode, 32'h0000_3143);
    send_and_check("ff0", 8'hF0, 1'b0, 1'b0, 1'b0);
    check("ff0_const", keyCode, 32'h3143_4630);
    send_and_check("f1c_b", 8'h1C, 1'b0, 1'b0, 1'b0);
    check("f1c_b_const", keyCode, 32'h4630_3143);
    send_and_check("f29_badpar", 8'h29, 1'b1, 1'b0, 1'b0);
    check("f29_held", keyCode, 32'h4630_3143);
    send_and_check("f23", 8'h23, 1'b0, 1'b0, 1'b0);
    check("f23_low", 32'(keyCode[15:0]), 32'h3233);
    send_and_check("f55_badstop", 8'h55, 1'b0, 1'b1, 1'b0);

    // Partial frame followed by silence must time out exactly once.
    kv0 = kv_cnt;
    e0  = err_cnt;
    send_bits(make_frame(8'h5A, 1'b0, 1'b0), 0, 3, 1'b0);
    repeat (TIMEOUT_CYCLES + 10 + HALF) @(posedge clk);
    check("tmo_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("tmo_valid_pulses", 32'(kv_cnt - kv0), 32'd0);
    check("tmo_latency_in_window",
          32'((err_cyc - last_fall >= TIMEOUT_CYCLES) &&
              (err_cyc - last_fall <= TIMEOUT_CYCLES + 30)), 32'd1);
    send_and_check("fe0", 8'hE0, 1'b0, 1'b0, 1'b0);
    check("fe0_low", 32'(keyCode[15:0]), 32'h4530);

    send_and_check("glitch_1c", 8'h1C, 1'b0, 1'b0, 1'b1);
    check("glitch_1c_low", 32'(keyCode[15:0]), 32'h3143);

    // Reset mid-frame; the leftover bits form a garbled partial frame that times out.
    kv0 = kv_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 0, 4, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    hist.delete();
    check("midrst_key", keyCode, 32'h0);
    e0 = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 5, 10, 1'b0);
    repeat (TIMEOUT_CYCLES + 100) @(posedge clk);
    check("midrst_no_valid", 32'(kv_cnt - kv0), 32'd0);
    check("midrst_garble_err", 32'(err_cnt - e0), 32'd1);
    send_and_check("midrst_f23", 8'h23, 1'b0, 1'b0, 1'b0);
    check("midrst_f23_const", keyCode, 32'h0000_3233);

    for (int i = 0; i < 12; i++) begin
      b  = 8'($urandom_range(0, 255));
      fp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 7) == 0);
      send_and_check($sformatf("rnd%0d_%h", i, b), b, fp, bs, bit'($urandom_range(0, 1)));
    end

    check("no_overlap", 32'(both_viol), 32'd0);
    check("pulse_width", 32'(width_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
